// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture path.
// Holds the active-low segment patterns (a..g on bits 6..0), the special
// BCD codes for blank and undecodable digits, the capture FSM state
// encoding and the per-digit decode payload.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
  localparam logic [BCD_W-1:0] BCD_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    STABLE,
    CAPTURED
  } state_e;

  // Decoded digit: BCD value plus invalid-pattern flag.
  typedef struct packed {
    logic [BCD_W-1:0] bcd;
    logic             err;
  } digit_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Frame handshake bundle between seg7_capture (master) and its consumer
// (slave): out_bcd / out_err (and out_dp when SEG7_CAPTURE_DP_EN is
// defined) qualified by out_valid, accepted with out_ready.
interface seg7_capture_if #(
  parameter int unsigned NDIG = 4
);
  logic [4*NDIG-1:0] out_bcd;
  logic [NDIG-1:0]   out_err;
  logic              out_valid;
  logic              out_ready;
`ifdef SEG7_CAPTURE_DP_EN
  logic [NDIG-1:0]   out_dp;

  modport master (output out_bcd, output out_err, output out_dp,
                  output out_valid, input out_ready);
  modport slave  (input out_bcd, input out_err, input out_dp,
                  input out_valid, output out_ready);
`else
  modport master (output out_bcd, output out_err,
                  output out_valid, input out_ready);
  modport slave  (input out_bcd, input out_err,
                  input out_valid, output out_ready);
`endif
endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD decoder.
// Ports: seg_i    - active-low segments a..g on bits 6..0
//        dig_c_o  - {bcd, err}; blank gives BCD_BLANK/err=0,
//                   unknown patterns give BCD_ERR/err=1
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output digit_t           dig_c_o
);

  always_comb begin
    dig_c_o.bcd = BCD_ERR;
    dig_c_o.err = 1'b1;
    case (seg_i)
      SEG_0:     begin dig_c_o.bcd = 4'd0;      dig_c_o.err = 1'b0; end
      SEG_1:     begin dig_c_o.bcd = 4'd1;      dig_c_o.err = 1'b0; end
      SEG_2:     begin dig_c_o.bcd = 4'd2;      dig_c_o.err = 1'b0; end
      SEG_3:     begin dig_c_o.bcd = 4'd3;      dig_c_o.err = 1'b0; end
      SEG_4:     begin dig_c_o.bcd = 4'd4;      dig_c_o.err = 1'b0; end
      SEG_5:     begin dig_c_o.bcd = 4'd5;      dig_c_o.err = 1'b0; end
      SEG_6:     begin dig_c_o.bcd = 4'd6;      dig_c_o.err = 1'b0; end
      SEG_7:     begin dig_c_o.bcd = 4'd7;      dig_c_o.err = 1'b0; end
      SEG_8:     begin dig_c_o.bcd = 4'd8;      dig_c_o.err = 1'b0; end
      SEG_9:     begin dig_c_o.bcd = 4'd9;      dig_c_o.err = 1'b0; end
      SEG_BLANK: begin dig_c_o.bcd = BCD_BLANK; dig_c_o.err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Receive side of a multiplexed 7-segment display: samples the segment
// bus and digit enables, debounces each digit, decodes it to BCD and
// assembles a frame published over a valid/ready handshake.
// Ports: clk, rst    - clock, synchronous active-high reset
//        seg_n       - segments a..g (bits 6..0), active low
//        an_n        - digit enables, active low, one-hot-low when legal
//        dp_n        - decimal point, active low (SEG7_CAPTURE_DP_EN only)
//        overrun     - sticky flag: a complete frame was dropped
//        out_if      - frame handshake (master side)
// Optional feature macro: SEG7_CAPTURE_DP_EN adds dp_n / out_dp.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_n,
  input  logic [NDIG-1:0]  an_n,
`ifdef SEG7_CAPTURE_DP_EN
  input  logic             dp_n,
`endif
  output logic             overrun,
  seg7_capture_if.master   out_if
);

  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
`ifdef SEG7_CAPTURE_DP_EN
  localparam int unsigned PIN_W = NDIG + SEG_W + 1;
`else
  localparam int unsigned PIN_W = NDIG + SEG_W;
`endif

  logic [PIN_W-1:0]             pins_c;
  logic [PIN_W-1:0]             smp_q;
  logic [NDIG-1:0]              an_smp_c;
  logic                         legal_c;
  logic [IDX_W-1:0]             idx_c;
  digit_t                       dig_c;
  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         cap_c;
  logic                         publish_c;
  logic [NDIG-1:0]              mask_q, mask_d;
  logic [NDIG-1:0][BCD_W-1:0]   shadow_q;
  logic [NDIG-1:0]              err_sh_q;
`ifdef SEG7_CAPTURE_DP_EN
  logic [NDIG-1:0]              dp_sh_q;

  assign pins_c = {dp_n, an_n, seg_n};
`else
  assign pins_c = {an_n, seg_n};
`endif

  assign an_smp_c  = smp_q[SEG_W +: NDIG];
  assign legal_c   = $onehot(~an_smp_c);
  assign publish_c = &mask_q;

  // Index of the enabled (low) digit in the registered sample.
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_smp_c[i]) idx_c = IDX_W'(i);
    end
  end

  seg7_to_bcd u_dec (
    .seg_i   (smp_q[SEG_W-1:0]),
    .dig_c_o (dig_c)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce FSM: capture once the pins match the sample STABLE_CYC times.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_c   = 1'b0;
    if (!legal_c) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
        STABLE: begin
          if (pins_c == smp_q) begin
            if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
              cap_c   = 1'b1;
              state_d = CAPTURED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        CAPTURED: begin
          if (pins_c != smp_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A publish edge clears the mask; a capture marks its digit present.
  always_comb begin
    mask_d = publish_c ? '0 : mask_q;
    if (cap_c) mask_d[idx_c] = 1'b1;
  end

  // Sampler, shadow frame and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q             <= '1;
      mask_q            <= '0;
      shadow_q          <= '0;
      err_sh_q          <= '0;
      overrun           <= 1'b0;
      out_if.out_bcd    <= '0;
      out_if.out_err    <= '0;
      out_if.out_valid  <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
      dp_sh_q           <= '0;
      out_if.out_dp     <= '0;
`endif
    end else begin
      smp_q  <= pins_c;
      mask_q <= mask_d;
      if (cap_c) begin
        shadow_q[idx_c] <= dig_c.bcd;
        err_sh_q[idx_c] <= dig_c.err;
`ifdef SEG7_CAPTURE_DP_EN
        dp_sh_q[idx_c]  <= ~smp_q[PIN_W-1];
`endif
      end
      if (publish_c) begin
        if (!out_if.out_valid || out_if.out_ready) begin
          out_if.out_bcd   <= shadow_q;
          out_if.out_err   <= err_sh_q;
          out_if.out_valid <= 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
          out_if.out_dp    <= dp_sh_q;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_if.out_valid && out_if.out_ready) begin
        out_if.out_valid <= 1'b0;
      end
    end
  end

endmodule
